// File: rtl/pkg_cpu.sv
// -----------------------------------------------------------------------------
// pkg_cpu
// Shared CPU-side definitions: access-size encoding, address width, and the
// types used by the memory bus controller (FSM state enum and the request
// record that travels through the skid buffer onto the memory bus).
// -----------------------------------------------------------------------------
package pkg_cpu;

    // Data access size as seen by the core and tb_memory
    localparam logic cpu_data_acc_sz_8  = 1'b0;
    localparam logic cpu_data_acc_sz_16 = 1'b1;

    // Byte address is cpu_addr_msb_pos+1 bits wide
    localparam int cpu_addr_msb_pos = 15;

    typedef enum logic [1:0] {
        MC_IDLE    = 2'd0,
        MC_DRIVE   = 2'd1,
        MC_CAPTURE = 2'd2,
        MC_RESP    = 2'd3
    } mem_ctrl_state_t;

    typedef struct packed {
        logic [cpu_addr_msb_pos:0] addr;
        logic [15:0]               wdata;
        logic                      sz;
        logic                      we;
    } mem_req_t;

endpackage

// File: rtl/cpu_mem_bus_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_mem_bus_ctrl_if
// Bundles the three channels of the memory bus controller:
//   request  : req_valid/req_ready, req_addr, req_wdata, req_sz, req_we
//   response : rsp_valid/rsp_ready, rsp_rdata, rsp_was_write
//   memory   : mem_addr, mem_wdata, mem_sz, mem_we, mem_rdata
// Modports:
//   slave  - the controller (accepts requests, drives the memory bus)
//   master - the environment (core on the request side, memory on mem_*)
// -----------------------------------------------------------------------------
interface cpu_mem_bus_ctrl_if;
    import pkg_cpu::*;

    logic                      req_valid;
    logic                      req_ready;
    logic [cpu_addr_msb_pos:0] req_addr;
    logic [15:0]               req_wdata;
    logic                      req_sz;
    logic                      req_we;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [15:0]               rsp_rdata;
    logic                      rsp_was_write;

    logic [cpu_addr_msb_pos:0] mem_addr;
    logic [15:0]               mem_wdata;
    logic                      mem_sz;
    logic                      mem_we;
    logic [15:0]               mem_rdata;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_sz, req_we,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_was_write,
        input  rsp_ready,
        output mem_addr, mem_wdata, mem_sz, mem_we,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_sz, req_we,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_was_write,
        output rsp_ready,
        input  mem_addr, mem_wdata, mem_sz, mem_we,
        output mem_rdata
    );

endinterface

// File: rtl/mem_req_skid.sv
// -----------------------------------------------------------------------------
// mem_req_skid
// One-entry holding register for a mem_req_t with a full flag.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   push        - store push_data (entry becomes full)
//   pop         - release the entry (ignored when push is also set, since the
//                 new data replaces the old one)
//   push_data   - request to store
//   head        - stored request
//   full        - entry currently holds a request
//   full_next   - value full will take after this edge, so the owner can
//                 register its ready/busy outputs without a cycle of lag
// -----------------------------------------------------------------------------
module mem_req_skid
    import pkg_cpu::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  logic     pop,
    input  mem_req_t push_data,
    output mem_req_t head,
    output logic     full,
    output logic     full_next
);

    mem_req_t data_q, data_d;
    logic     full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (push) begin
            data_d = push_data;
            full_d = 1'b1;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign head      = data_q;
    assign full      = full_q;
    assign full_next = full_d;

endmodule

// File: rtl/cpu_mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_mem_bus_ctrl
// Memory access controller between the core's load/store/fetch port and
// tb_memory. One request is in flight at a time; it is held on mem_* for
// HOLD_CYCLES edges so that at least one of tb_memory's alternate-edge access
// slots sees it, then read data (or write completion) is returned on the
// response channel. A one-entry skid lets the core post the next request
// while the current one is in flight.
// Ports:
//   clk    - memory clock (shared with tb_memory)
//   reset  - synchronous, active-high
//   bus    - cpu_mem_bus_ctrl_if.slave (request, response, memory channels)
//   busy   - controller not idle or skid holding a request
// All outputs are registered.
// -----------------------------------------------------------------------------
module cpu_mem_bus_ctrl
    import pkg_cpu::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    cpu_mem_bus_ctrl_if.slave bus,
    output logic              busy
);

    // tb_memory only accepts on every other edge, so a one-edge hold can
    // miss its slot entirely.
    generate
        if (HOLD_CYCLES < 2) begin : g_hold_check
            $error("cpu_mem_bus_ctrl: HOLD_CYCLES must be >= 2, got %0d", HOLD_CYCLES);
        end
    endgenerate

    localparam int            CW       = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

    mem_ctrl_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    mem_req_t        mem_req_q, mem_req_d;
    logic            cur_we_q, cur_we_d;       // we of the active request; mem_we drops before capture
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_was_write_q, rsp_was_write_d;
    logic            busy_q, busy_d;

    mem_req_t        in_req;
    mem_req_t        skid_head;
    logic            skid_push, skid_pop, skid_full, skid_full_next;
    logic            accept, rsp_hs;

    assign in_req = '{addr: bus.req_addr, wdata: bus.req_wdata, sz: bus.req_sz, we: bus.req_we};
    assign accept = bus.req_valid & req_ready_q;
    assign rsp_hs = rsp_valid_q & bus.rsp_ready;

    mem_req_skid u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (skid_push),
        .pop       (skid_pop),
        .push_data (in_req),
        .head      (skid_head),
        .full      (skid_full),
        .full_next (skid_full_next)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        mem_req_d       = mem_req_q;
        cur_we_d        = cur_we_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_was_write_d = rsp_was_write_q;
        skid_push       = 1'b0;
        skid_pop        = 1'b0;

        case (state_q)
            MC_IDLE: begin
                if (accept) begin
                    mem_req_d = in_req;
                    cur_we_d  = in_req.we;
                    cnt_d     = CNT_LOAD;
                    state_d   = MC_DRIVE;
                end
            end

            MC_DRIVE: begin
                skid_push = accept;
                if (cnt_q == '0) begin
                    // Address/size stay put; only the write strobe retires
                    mem_req_d.we = 1'b0;
                    state_d      = MC_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            MC_CAPTURE: begin
                skid_push       = accept;
                rsp_valid_d     = 1'b1;
                rsp_was_write_d = cur_we_q;
                if (cur_we_q) begin
                    rsp_rdata_d = 16'h0000;
                end else if (mem_req_q.sz == cpu_data_acc_sz_8) begin
                    rsp_rdata_d = {8'h00, bus.mem_rdata[7:0]};
                end else begin
                    rsp_rdata_d = bus.mem_rdata;
                end
                state_d = MC_RESP;
            end

            MC_RESP: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    if (skid_full) begin
                        // req_ready is low while the skid is full, so no
                        // new request can arrive on this edge
                        skid_pop  = 1'b1;
                        mem_req_d = skid_head;
                        cur_we_d  = skid_head.we;
                        cnt_d     = CNT_LOAD;
                        state_d   = MC_DRIVE;
                    end else if (accept) begin
                        // Request arriving with the handshake goes straight
                        // onto the bus instead of parking in the skid
                        mem_req_d = in_req;
                        cur_we_d  = in_req.we;
                        cnt_d     = CNT_LOAD;
                        state_d   = MC_DRIVE;
                    end else begin
                        state_d = MC_IDLE;
                    end
                end else begin
                    skid_push = accept;
                end
            end

            default: state_d = MC_IDLE;
        endcase

        req_ready_d = (state_d == MC_IDLE) | ~skid_full_next;
        busy_d      = (state_d != MC_IDLE) | skid_full_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= MC_IDLE;
            cnt_q           <= '0;
            mem_req_q       <= '0;
            cur_we_q        <= 1'b0;
            req_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= 16'h0000;
            rsp_was_write_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            mem_req_q       <= mem_req_d;
            cur_we_q        <= cur_we_d;
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_was_write_q <= rsp_was_write_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_was_write = rsp_was_write_q;
    assign bus.mem_addr      = mem_req_q.addr;
    assign bus.mem_wdata     = mem_req_q.wdata;
    assign bus.mem_sz        = mem_req_q.sz;
    assign bus.mem_we        = mem_req_q.we;
    assign busy              = busy_q;

endmodule
